// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter with per-register pending-write scoreboard
module regfile_wb_arbiter #(
  parameter int DBITS = 32
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             req0,
  input  logic [3:0]       rd0,
  input  logic [DBITS-1:0] data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [3:0]       rd1,
  input  logic [DBITS-1:0] data1,
  output logic             ack1,
  input  logic             rsvEn,
  input  logic [3:0]       rsvReg,
  output logic             rsvReady,
  input  logic [3:0]       rs1,
  input  logic [3:0]       rs2,
  output logic             rs1Busy,
  output logic             rs2Busy,
  output logic             wrtEn,
  output logic [3:0]       wrtReg,
  output logic [DBITS-1:0] wrtData
);

  logic             prio_q;
  logic             wrt_en_q;
  logic [3:0]       wrt_reg_q;
  logic [DBITS-1:0] wrt_data_q;
  logic [1:0]       pend_q [16];
  logic [1:0]       pend_d [16];
  logic             rsv_fire;

  // Grant: a lone requester always wins; on a tie the prio port wins
  always_comb begin
    ack0 = req0 & (~req1 | ~prio_q);
    ack1 = req1 & (~req0 |  prio_q);
  end

  assign rsvReady = (pend_q[rsvReg] != 2'd3);
  assign rsv_fire = rsvEn & rsvReady;
  assign rs1Busy  = (pend_q[rs1] != 2'd0);
  assign rs2Busy  = (pend_q[rs2] != 2'd0);

  assign wrtEn    = wrt_en_q;
  assign wrtReg   = wrt_reg_q;
  assign wrtData  = wrt_data_q;

  // Scoreboard next state: reserve and commit on the same register cancel out;
  // a commit to an idle register leaves it at zero
  always_comb begin
    for (int r = 0; r < 16; r++) begin
      pend_d[r] = pend_q[r];
      if (rsv_fire && (rsvReg == 4'(r)) && !(wrt_en_q && (wrt_reg_q == 4'(r)))) begin
        pend_d[r] = pend_q[r] + 2'd1;
      end else if (wrt_en_q && (wrt_reg_q == 4'(r)) && !(rsv_fire && (rsvReg == 4'(r)))) begin
        if (pend_q[r] != 2'd0) begin
          pend_d[r] = pend_q[r] - 2'd1;
        end
      end
    end
  end

  // Priority flips away from whichever port was just granted
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prio_q <= 1'b0;
    end else if (ack0) begin
      prio_q <= 1'b1;
    end else if (ack1) begin
      prio_q <= 1'b0;
    end
  end

  // Output stage: launch the granted write; address/data hold when idle
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wrt_en_q   <= 1'b0;
      wrt_reg_q  <= 4'd0;
      wrt_data_q <= '0;
    end else begin
      wrt_en_q <= ack0 | ack1;
      if (ack0) begin
        wrt_reg_q  <= rd0;
        wrt_data_q <= data0;
      end else if (ack1) begin
        wrt_reg_q  <= rd1;
        wrt_data_q <= data1;
      end
    end
  end

  // Pending-write counters
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int r = 0; r < 16; r++) begin
        pend_q[r] <= 2'd0;
      end
    end else begin
      for (int r = 0; r < 16; r++) begin
        pend_q[r] <= pend_d[r];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        resetN;
  logic        req0, req1, rsvEn;
  logic [3:0]  rd0, rd1, rsvReg, rs1, rs2;
  logic [31:0] data0, data1;
  logic        ack0, ack1, rsvReady, rs1Busy, rs2Busy, wrtEn;
  logic [3:0]  wrtReg;
  logic [31:0] wrtData;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DBITS(32)) dut (
    .clk(clk), .resetN(resetN),
    .req0(req0), .rd0(rd0), .data0(data0), .ack0(ack0),
    .req1(req1), .rd1(rd1), .data1(data1), .ack1(ack1),
    .rsvEn(rsvEn), .rsvReg(rsvReg), .rsvReady(rsvReady),
    .rs1(rs1), .rs2(rs2), .rs1Busy(rs1Busy), .rs2Busy(rs2Busy),
    .wrtEn(wrtEn), .wrtReg(wrtReg), .wrtData(wrtData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetN = 1'b0; req0 = 0; req1 = 0; rsvEn = 0;
    rd0 = 0; rd1 = 0; rsvReg = 0; rs1 = 0; rs2 = 0; data0 = 0; data1 = 0;
    step();
    chk("rst_wrtEn", wrtEn, 0);
    chk("rst_wrtReg", wrtReg, 0);
    chk("rst_wrtData", wrtData, 0);
    chk("rst_rsvReady", rsvReady, 1);
    chk("rst_rs1Busy", rs1Busy, 0);
    chk("rst_rs2Busy", rs2Busy, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    resetN = 1'b1;
    step();

    // Single port-0 write
    req0 = 1; rd0 = 4'd5; data0 = 32'hA5; #1;
    chk("t1_ack0", ack0, 1);
    chk("t1_ack1", ack1, 0);
    step();
    req0 = 0; #1;
    chk("t1_wrtEn", wrtEn, 1);
    chk("t1_wrtReg", wrtReg, 5);
    chk("t1_wrtData", wrtData, 32'hA5);
    step();
    rs1 = 4'd5; #1;
    chk("t1_wrtEn_drop", wrtEn, 0);
    chk("t1_wrtReg_hold", wrtReg, 5);
    chk("t1_r5_unreserved", rs1Busy, 0);

    // Fresh reset so priority starts at port 0, then both ports contend
    resetN = 0; #1; resetN = 1;
    step();
    req0 = 1; rd0 = 4'd1; data0 = 32'h11;
    req1 = 1; rd1 = 4'd2; data1 = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2_ack0_%0d", i), ack0, (i % 2 == 0));
      chk($sformatf("t2_ack1_%0d", i), ack1, (i % 2 == 1));
      if (i > 0) begin
        chk($sformatf("t2_wrtEn_%0d", i), wrtEn, 1);
        chk($sformatf("t2_wrtReg_%0d", i), wrtReg, (i % 2 == 1) ? 1 : 2);
      end
      step();
    end
    req0 = 0; req1 = 0; #1;
    chk("t2_wrtEn_last", wrtEn, 1);
    chk("t2_wrtReg_last", wrtReg, 2);
    chk("t2_wrtData_last", wrtData, 32'h22);
    step();

    // Reserve r7, port 1 commits it
    rsvEn = 1; rsvReg = 4'd7; #1;
    chk("t3_rsvReady", rsvReady, 1);
    step();
    rsvEn = 0; rs1 = 4'd7; #1;
    chk("t3_busy_rsv", rs1Busy, 1);
    req1 = 1; rd1 = 4'd7; data1 = 32'h77; #1;
    chk("t3_ack1", ack1, 1);
    step();
    req1 = 0; #1;
    chk("t3_wrtEn", wrtEn, 1);
    chk("t3_wrtReg", wrtReg, 7);
    chk("t3_busy_during_wr", rs1Busy, 1);
    step();
    chk("t3_busy_after_wr", rs1Busy, 0);

    // Saturating reservations on r3, then three commits
    rsvEn = 1; rsvReg = 4'd3; rs2 = 4'd3;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t4_rsvReady_%0d", i), rsvReady, (i < 3));
      step();
    end
    rsvEn = 0; #1;
    chk("t4_busy_full", rs2Busy, 1);
    rd0 = 4'd3; data0 = 32'h33;
    for (int i = 0; i < 4; i++) begin
      req0 = (i < 3); #1;
      if (i > 0) chk($sformatf("t4_busy_%0d", i), rs2Busy, 1);
      step();
    end
    chk("t4_busy_clear", rs2Busy, 0);

    // Reserve and commit of r4 at the same edge
    rsvEn = 1; rsvReg = 4'd4;
    step();
    rsvEn = 0; req1 = 1; rd1 = 4'd4; data1 = 32'h44; #1;
    chk("t5_ack1", ack1, 1);
    step();
    req1 = 0; rsvEn = 1; rsvReg = 4'd4; rs1 = 4'd4; #1;
    chk("t5_wrtEn", wrtEn, 1);
    chk("t5_wrtReg", wrtReg, 4);
    chk("t5_busy_pre", rs1Busy, 1);
    step();
    rsvEn = 0; #1;
    chk("t5_busy_same_edge", rs1Busy, 1);
    req0 = 1; rd0 = 4'd4; data0 = 32'h04; #1;
    chk("t5_ack0", ack0, 1);
    step();
    req0 = 0;
    step();
    chk("t5_busy_final", rs1Busy, 0);
    // Commit to unreserved r9
    req0 = 1; rd0 = 4'd9; data0 = 32'h99; rs2 = 4'd9;
    step();
    req0 = 0;
    step();
    chk("t5_r9_sat", rs2Busy, 0);

    // Reset in the middle of a write with r2 double-reserved
    rsvEn = 1; rsvReg = 4'd2;
    step();
    step();
    rsvEn = 0; req0 = 1; rd0 = 4'd2; data0 = 32'h22; #1;
    chk("t6_ack0", ack0, 1);
    step();
    req0 = 0; rs1 = 4'd2; rs2 = 4'd4; #1;
    chk("t6_wrtEn_pre", wrtEn, 1);
    chk("t6_busy_pre", rs1Busy, 1);
    resetN = 0; #1;
    chk("t6_wrtEn_rst", wrtEn, 0);
    chk("t6_wrtReg_rst", wrtReg, 0);
    chk("t6_busy_rst", rs1Busy, 0);
    chk("t6_r4_rst", rs2Busy, 0);
    req0 = 1; req1 = 1; #1;
    chk("t6_prio_ack0", ack0, 1);
    chk("t6_prio_ack1", ack1, 0);
    req0 = 0; req1 = 0;
    step();
    resetN = 1;
    step();
    chk("t6_no_write", wrtEn, 0);
    chk("t6_busy_post", rs1Busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 16-entry register file. Shares the register file's single write port between two producers: port 0 (ALU) and port 1 (load unit). Grants are round-robin, and each accepted write is launched from a one-stage output register. A per-register pending-write counter lets the issue logic reserve destinations and stall on RAW/WAW hazards.

## Interface
Parameters:
- DBITS, 32, data width; matches the register file data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- resetN  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 (ALU) write request.
- rd0  in  4  port 0 destination register.
- data0  in  DBITS  port 0 write data.
- ack0  out  1  port 0 request accepted this cycle.
- req1  in  1  port 1 (load) write request.
- rd1  in  4  port 1 destination register.
- data1  in  DBITS  port 1 write data.
- ack1  out  1  port 1 request accepted this cycle.
- rsvEn  in  1  reserve a destination (instruction issue).
- rsvReg  in  4  register being reserved.
- rsvReady  out  1  reservation of rsvReg is possible this cycle.
- rs1, rs2  in  4  source registers to check.
- rs1Busy, rs2Busy  out  1  source has a pending write.
- wrtEn  out  1  register file write enable (registered).
- wrtReg  out  4  register file write address (registered).
- wrtData  out  DBITS  register file write data (registered).

## Operation
State:
- prio: 1 bit, the port with priority on a tie.
- pend[0..15]: 2-bit pending-write counters.
- Output stage: wrtEn, wrtReg, wrtData.

Arbitration (combinational, same cycle as the request):
- Only req0 high: ack0=1.
- Only req1 high: ack1=1.
- Both high: ack goes to port prio.
- At most one ack per cycle.
- A requester holds req, rd and data stable until it sees ack.

Prio update:
- On any accepted request from port k, prio <= 1-k at the edge.
- No request: prio holds.

Output stage, at each edge:
- wrtEn <= ack0|ack1.
- On ack, wrtReg/wrtData <= the granted port's rd/data.
- With no ack, wrtReg/wrtData hold their values; only wrtEn drops.
- The register file always accepts, so the output stage never stalls and the arbiter never back-pressures beyond losing arbitration.

Scoreboard:
- rsvReady = (pend[rsvReg] != 3).
- Reserve event = rsvEn & rsvReady. rsvEn while rsvReady=0 is ignored.
- Commit event = wrtEn, for register wrtReg (the edge where the register file is actually written).
- At each edge, for each register r:
  - +1 if reserved and not committed.
  - −1 if committed and not reserved.
  - Unchanged if both or neither.
- Decrement saturates at 0: a commit to an unreserved register leaves pend at 0.
- rsNBusy = (pend[rsN] != 0), combinational.
- Busy remains 1 during the cycle wrtEn is high for that register. It clears after the edge that writes the register file, so a read in the following cycle returns the new value.

## Timing
Reset (resetN=0, asynchronous) forces:
- prio=0, all pend=0.
- wrtEn=0, wrtReg=0, wrtData=0.
- ack0/ack1 are combinational: they follow req and prio.
- rsvReady=1, rs1Busy=rs2Busy=0.

Latency:
- Request accepted in cycle N (ack high).
- wrtEn high in cycle N+1.
- Register file written at the end of N+1; pend decremented at the same edge.

Throughput:
- One write per cycle.
- Back-to-back grants are allowed; wrtEn stays high continuously.

Alternation: with both ports requesting continuously, grants alternate 0,1,0,1…

Reset mid-operation discards the in-flight write and all reservations; no write reaches the register file after reset asserts.

## Test plan
- After reset: req0=1, rd0=5, data0=0xA5 → ack0=1 in cycle 0; wrtEn=1, wrtReg=5, wrtData=0xA5 in cycle 1; wrtEn=0 in cycle 2.
- req0 and req1 held high for 4 cycles (rd0=1, rd1=2) → ack order 0,1,0,1; wrtReg sequence 1,2,1,2 with wrtEn continuously high.
- Reserve r7, then check rs1=7 → rs1Busy=1. Port 1 writes r7 → rs1Busy stays 1 while wrtEn is high, and reads 0 the next cycle.
- Reserve r3 four times → pend counts 1,2,3; the fourth rsvEn sees rsvReady=0 and is ignored. Three commits to r3 → rs2Busy (rs2=3) drops only after the third.
- Same edge: reserve r4 while committing r4 with pend[4]=1 → pend[4] stays 1, rs1Busy stays 1. Commit to r9 with pend[9]=0 → pend stays 0.
- Assert resetN=0 during a cycle with wrtEn=1 and pend[2]=2 → wrtEn=0 immediately, rs1Busy(rs1=2)=0, prio=0.
